zeroriscy_bus_dma: RTL and testbench
====================================

# zeroriscy_bus_dma

Word-copy engine acting as a bus initiator on the zero-riscy req/gnt/rvalid memory protocol, i.e. the requesting end of the interface our SRAM blocks respond to. Given source, destination and word count, it reads each word from `src` and writes it to `dst`, one transaction outstanding at a time. It sits beside the core on the data-side interconnect. Typical uses are boot-ROM-to-instruction-RAM copies and test preloading.

## Interface
Parameters:
- `LEN_W`, 16: width of the word-count input.

Ports:
- `clk` in 1: clock. All state updates on rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: one-cycle launch pulse. Ignored while `busy`.
- `src_addr` in 32: source byte address. Bits [1:0] are ignored (forced 0).
- `dst_addr` in 32: destination byte address. Bits [1:0] are ignored (forced 0).
- `len` in LEN_W: number of 32-bit words to copy.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: sticky error flag. Set with `done` when aborted; cleared by the next accepted `start`.
- `m_req` out 1: bus request.
- `m_we` out 1: write enable. 0 = read.
- `m_be` out 4: byte enables. Always 4'hF while `m_req` is high.
- `m_addr` out 32: bus address.
- `m_wdata` out 32: write data.
- `m_rdata` in 32: read data, valid with `m_rvalid`.
- `m_gnt` in 1: grant. The request is accepted in a cycle with `m_req & m_gnt`.
- `m_rvalid` in 1: response valid. Exactly one per granted request, read or write.
- `m_err` in 1: response error, qualified by `m_rvalid`.

## Operation
- States:
  - IDLE: wait for `start`.
  - RD_REQ: `m_req`=1, `m_we`=0, `m_addr`=src pointer.
  - RD_WAIT: await `m_rvalid`; capture `m_rdata` into the data register.
  - WR_REQ: `m_req`=1, `m_we`=1, `m_addr`=dst pointer, `m_wdata`=data register.
  - WR_WAIT: await `m_rvalid`.
  - DONE: pulse `done`, return to IDLE.
- IDLE + `start`:
  - Latch pointers and remaining count; clear `err`.
  - If `len`==0, go to DONE; otherwise go to RD_REQ.
- RD_REQ/WR_REQ: hold `m_req`, `m_addr`, `m_we` and `m_wdata` stable until the grant. Advance to the matching WAIT state on `m_gnt`.
- RD_WAIT + `m_rvalid`:
  - `m_err`=1: set `err`, go to DONE.
  - Otherwise go to WR_REQ.
- WR_WAIT + `m_rvalid`:
  - `m_err`=1: set `err`, go to DONE.
  - Otherwise increment both pointers by 4 and decrement the count. Go to DONE if the count reaches 0, else to RD_REQ.
- Pointers wrap modulo 2^32 with no error.
- `m_req` is never high in a WAIT state, so at most one transaction is outstanding.
- `start` while `busy` has no effect, including `start` in the DONE cycle.
- Reset asserted mid-transfer:
  - All state returns to IDLE immediately and `m_req` drops.
  - Any outstanding response after reset release is ignored.

## Timing
- Reset values: `busy`=0, `done`=0, `err`=0, `m_req`=0, `m_we`=0, `m_be`=0, `m_addr`=0, `m_wdata`=0.
- `start` sampled at edge 0. From edge 1, `busy`=1 and `m_req`=1 with the first read address.
- With zero-wait responder (gnt tied 1, rvalid one cycle after grant): 4 cycles per word. A copy of N words has `done` high in cycle 4N+1 after `start`.
- `len`=0: `done` high in cycle 1, with no bus activity.
- `busy` falls in the same cycle `done` rises. `done` is high for exactly one cycle.
- All outputs are registered or decoded from state only. There is no combinational path from `m_gnt`/`m_rvalid` to `m_req`.

## Structure
- Package `zeroriscy_dma_pkg`: state enum `dma_state_e` and the constant `BE_WORD` = 4'hF.
- Single module. The datapath (two pointers, counter, data register) is too small to justify a sub-module.

## Test plan
- **Basic copy.** Zero-wait responder model; preload src 0x0000_0000..0x0000_000C = A0..A3; `len`=4, `dst`=0x0008_0000. Required: dst words equal A0..A3, `done` at cycle 17, `err`=0, exactly 4 reads and 4 writes.
- **Grant stalls.** Random `m_gnt` low 0–5 cycles and `m_rvalid` delay 1–4 cycles, `len`=8. Required: `m_addr`/`m_we`/`m_wdata` stable while `m_req & !m_gnt`; data correct; never two outstanding transactions.
- **Zero length.** `len`=0. Required: `done` at cycle 1, `m_req` never high, `busy` never high.
- **Error abort.** `m_err`=1 on the read response of word 2 of 5. Required: only words 0–1 written, `done`+`err` asserted, no further `m_req`. The next `start` clears `err`.
- **Wrap and ignored start.** `src`=0xFFFF_FFF8, `len`=3, with a `start` pulse mid-transfer. Required: read addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; the mid-transfer `start` is ignored. Address bits [1:0] of an unaligned `src` are ignored.
- **Reset mid-transfer.** Assert `rst_n`=0 while in WR_REQ. Required: all outputs at reset values in the same cycle; a subsequent `start` completes normally.

Source files
------------

// File: rtl/zeroriscy_dma_pkg.sv
// Shared types and constants for the zero-riscy bus word-copy engine.
package zeroriscy_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_WR_REQ,
    ST_WR_WAIT,
    ST_DONE
  } dma_state_e;

  localparam logic [3:0] BE_WORD = 4'hF;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/zeroriscy_bus_dma.sv
// Word-copy engine: reads src words and writes them to dst over the zero-riscy
// req/gnt/rvalid protocol with a single outstanding transaction.
module zeroriscy_bus_dma
  import zeroriscy_dma_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             m_req,
  output logic             m_we,
  output logic [3:0]       m_be,
  output logic [31:0]      m_addr,
  output logic [31:0]      m_wdata,
  input  logic [31:0]      m_rdata,
  input  logic             m_gnt,
  input  logic             m_rvalid,
  input  logic             m_err
);

  dma_state_e       r_state;
  logic [31:0]      r_src;
  logic [31:0]      r_dst;
  logic [LEN_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic             r_req;
  logic             r_we;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;

  logic [31:0]      w_src_align;
  logic [31:0]      w_dst_align;
  logic [31:0]      w_src_next;

  assign w_src_align = word_align(src_addr);
  assign w_dst_align = word_align(dst_addr);
  assign w_src_next  = r_src + 32'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_src <= w_src_align;
            r_dst <= w_dst_align;
            r_cnt <= len;
            r_err <= 1'b0;
            if (len == '0) begin
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_busy  <= 1'b1;
              r_req   <= 1'b1;
              r_we    <= 1'b0;
              r_addr  <= w_src_align;
              r_state <= ST_RD_REQ;
            end
          end
        end

        ST_RD_REQ: begin
          if (m_gnt) begin
            r_req   <= 1'b0;
            r_state <= ST_RD_WAIT;
          end
        end

        ST_RD_WAIT: begin
          if (m_rvalid) begin
            if (m_err) begin
              r_err   <= 1'b1;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              // The write-data output doubles as the word buffer.
              r_wdata <= m_rdata;
              r_req   <= 1'b1;
              r_we    <= 1'b1;
              r_addr  <= r_dst;
              r_state <= ST_WR_REQ;
            end
          end
        end

        ST_WR_REQ: begin
          if (m_gnt) begin
            r_req   <= 1'b0;
            r_state <= ST_WR_WAIT;
          end
        end

        ST_WR_WAIT: begin
          if (m_rvalid) begin
            r_we <= 1'b0;
            if (m_err) begin
              r_err   <= 1'b1;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_src <= w_src_next;
              r_dst <= r_dst + 32'd4;
              r_cnt <= r_cnt - LEN_W'(1);
              if (r_cnt == LEN_W'(1)) begin
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= ST_DONE;
              end else begin
                r_req   <= 1'b1;
                r_addr  <= w_src_next;
                r_state <= ST_RD_REQ;
              end
            end
          end
        end

        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign err     = r_err;
  assign m_req   = r_req;
  assign m_we    = r_we;
  assign m_be    = r_req ? BE_WORD : 4'h0;
  assign m_addr  = r_addr;
  assign m_wdata = r_wdata;

endmodule

// File: tb/tb_zeroriscy_bus_dma.sv
// Self-checking bench: vector table of copy jobs, a bus responder model with a
// scoreboard of expected transactions, plus a hand-written reset sequence.
module tb_zeroriscy_bus_dma;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [15:0] len;
  logic        busy;
  logic        done;
  logic        err;
  logic        m_req;
  logic        m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_gnt;
  logic        m_rvalid;
  logic        m_err;

  zeroriscy_bus_dma #(.LEN_W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .m_req    (m_req),
    .m_we     (m_we),
    .m_be     (m_be),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_rdata  (m_rdata),
    .m_gnt    (m_gnt),
    .m_rvalid (m_rvalid),
    .m_err    (m_err)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    int          len;
    int          max_stall;
    int          max_delay;
    int          err_idx;
    int          exp_cyc;
    logic        exp_err;
    logic        mid_start;
    logic [31:0] dbase;
  } vec_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  txn_t        exp_q[$];
  logic [31:0] mem [logic [31:0]];

  int          cfg_stall = 0;
  int          cfg_delay = 1;
  int          cfg_err_idx = -1;
  int          rd_idx = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bus responder: decides grant/response on the falling edge, checks each
  // accepted request against the scoreboard.
  initial begin
    int          pend;
    int          stall_left;
    bit          req_seen;
    bit          stall_prev;
    logic [31:0] h_addr, h_wdata, p_data;
    logic        h_we, p_err;
    txn_t        t;
    pend = 0; stall_left = 0; req_seen = 0; stall_prev = 0;
    h_addr = '0; h_wdata = '0; h_we = 1'b0; p_data = '0; p_err = 1'b0;
    m_gnt = 1'b0; m_rvalid = 1'b0; m_err = 1'b0; m_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 0; req_seen = 0; stall_prev = 0;
        m_gnt = 1'b0; m_rvalid = 1'b0; m_err = 1'b0; m_rdata = '0;
        continue;
      end
      if (stall_prev) begin
        check("hold_req", m_req, 1'b1);
        check("hold_addr", m_addr, h_addr);
        check("hold_we", m_we, h_we);
        check("hold_wdata", m_wdata, h_wdata);
      end
      if (m_req) check("one_outstanding", pend, 0);
      m_rvalid = 1'b0;
      m_err    = 1'b0;
      m_rdata  = '0;
      if (pend != 0) begin
        pend--;
        if (pend == 0) begin
          m_rvalid = 1'b1;
          m_rdata  = p_data;
          m_err    = p_err;
        end
      end
      m_gnt = 1'b0;
      stall_prev = 0;
      if (m_req && pend == 0) begin
        if (!req_seen) begin
          req_seen = 1;
          stall_left = $urandom_range(0, cfg_stall);
        end
        if (stall_left == 0) begin
          m_gnt = 1'b1;
          req_seen = 0;
          pend = $urandom_range(1, cfg_delay);
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_txn: got addr %h we %b expected no request", m_addr, m_we);
          end else begin
            t = exp_q.pop_front();
            check("txn_we", m_we, t.we);
            check("txn_addr", m_addr, t.addr);
            check("txn_be", m_be, 4'hF);
            if (t.we) check("txn_wdata", m_wdata, t.data);
          end
          if (m_we) begin
            mem[m_addr] = m_wdata;
            p_data = '0;
            p_err  = 1'b0;
          end else begin
            p_data = mem.exists(m_addr) ? mem[m_addr] : 32'hDEAD_BEEF;
            p_err  = (rd_idx == cfg_err_idx);
            rd_idx++;
          end
        end else begin
          stall_left--;
          stall_prev = 1;
          h_addr = m_addr; h_we = m_we; h_wdata = m_wdata;
        end
      end
    end
  end

  task automatic run_vec(input vec_t v);
    logic [31:0] as, ad, expw;
    int          nw, cyc;
    bit          busy_bad, req_bad;
    as = v.src & ~32'h3;
    ad = v.dst & ~32'h3;
    for (int i = 0; i < v.len; i++) begin
      mem[as + 32'(4 * i)] = v.dbase + 32'(i);
      mem[ad + 32'(4 * i)] = 32'h5EED_0000 + 32'(i);
    end
    nw = (v.err_idx >= 0 && v.err_idx < v.len) ? v.err_idx : v.len;
    for (int i = 0; i < v.len; i++) begin
      exp_q.push_back('{we: 1'b0, addr: as + 32'(4 * i), data: 32'h0});
      if (i == v.err_idx) break;
      exp_q.push_back('{we: 1'b1, addr: ad + 32'(4 * i), data: v.dbase + 32'(i)});
    end
    cfg_stall = v.max_stall;
    cfg_delay = v.max_delay;
    cfg_err_idx = v.err_idx;
    rd_idx = 0;

    @(negedge clk);
    src_addr = v.src;
    dst_addr = v.dst;
    len      = 16'(v.len);
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    src_addr = 32'hBAD0_0000;
    dst_addr = 32'hBAD1_0000;
    len      = 16'hFFFF;
    cyc = 1;
    check("err_cleared", err, 1'b0);
    busy_bad = 0;
    while (!done && cyc < 600) begin
      if (!busy) busy_bad = 1;
      if (v.mid_start) begin
        start    = (cyc == 5);
        src_addr = 32'h0000_0700;
        len      = 16'd7;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("done_seen", done, 1'b1);
    if (v.exp_cyc >= 0) check("done_cycle", cyc, v.exp_cyc);
    check("busy_low_at_done", busy, 1'b0);
    check("busy_high_before_done", busy_bad, 1'b0);
    check("err_at_done", err, v.exp_err);
    if (v.mid_start) begin
      start    = 1'b1;
      src_addr = 32'h0000_0700;
      len      = 16'd7;
    end
    @(negedge clk);
    start = 1'b0;
    check("done_one_cycle", done, 1'b0);
    check("busy_after_done", busy, 1'b0);
    req_bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (m_req || busy) req_bad = 1;
    end
    check("idle_after_done", req_bad, 1'b0);
    check("err_sticky", err, v.exp_err);
    check("all_txns_seen", exp_q.size(), 0);
    for (int i = 0; i < v.len; i++) begin
      expw = (i < nw) ? v.dbase + 32'(i) : 32'h5EED_0000 + 32'(i);
      check("dst_word", mem[ad + 32'(4 * i)], expw);
    end
    $display("vec src=%h dst=%h len=%0d done_cycle=%0d err=%b", v.src, v.dst, v.len, cyc, err);
  endtask

  vec_t vecs[7];
  vec_t post;

  initial begin
    int wait_cyc;
    vecs[0] = '{32'h0000_0000, 32'h0008_0000, 4, 0, 1, -1, 17, 1'b0, 1'b0, 32'h0000_00A0};
    vecs[1] = '{32'h0000_0100, 32'h0008_1000, 8, 5, 4, -1, -1, 1'b0, 1'b0, 32'h1111_0000};
    vecs[2] = '{32'h0000_0200, 32'h0008_2000, 0, 0, 1, -1,  1, 1'b0, 1'b0, 32'h2222_0000};
    vecs[3] = '{32'h0000_0300, 32'h0008_3000, 5, 0, 1,  2, 11, 1'b1, 1'b0, 32'h3333_0000};
    vecs[4] = '{32'hFFFF_FFF8, 32'h0008_4000, 3, 0, 1, -1, 13, 1'b0, 1'b1, 32'h4444_0000};
    vecs[5] = '{32'h0000_0503, 32'h0008_5002, 2, 0, 1, -1,  9, 1'b0, 1'b0, 32'h5555_0000};
    vecs[6] = '{32'h0000_0600, 32'h0008_6000, 5, 3, 3, -1, -1, 1'b0, 1'b0, 32'h6666_0000};
    post    = '{32'h0000_0800, 32'h0008_8000, 2, 0, 1, -1,  9, 1'b0, 1'b0, 32'h8888_0000};

    rst_n = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
    #3;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_req", m_req, 1'b0);
    check("rst_we", m_we, 1'b0);
    check("rst_be", m_be, 4'h0);
    check("rst_addr", m_addr, 32'h0);
    check("rst_wdata", m_wdata, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 7; k++) run_vec(vecs[k]);

    // Reset asserted while a write request is pending.
    for (int i = 0; i < 4; i++) begin
      mem[32'h0000_0900 + 32'(4 * i)] = 32'h9999_0000 + 32'(i);
      exp_q.push_back('{we: 1'b0, addr: 32'h0000_0900 + 32'(4 * i), data: 32'h0});
      exp_q.push_back('{we: 1'b1, addr: 32'h0008_9000 + 32'(4 * i), data: 32'h9999_0000 + 32'(i)});
    end
    cfg_stall = 0; cfg_delay = 1; cfg_err_idx = -1; rd_idx = 0;
    @(negedge clk);
    src_addr = 32'h0000_0900; dst_addr = 32'h0008_9000; len = 16'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_cyc = 0;
    while (!(m_req && m_we) && wait_cyc < 50) begin
      @(negedge clk);
      wait_cyc++;
    end
    check("reach_wr_req", m_req && m_we, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_err", err, 1'b0);
    check("midrst_req", m_req, 1'b0);
    check("midrst_we", m_we, 1'b0);
    check("midrst_be", m_be, 4'h0);
    check("midrst_addr", m_addr, 32'h0);
    check("midrst_wdata", m_wdata, 32'h0);
    $display("reset mid-transfer: req=%b busy=%b addr=%h", m_req, busy, m_addr);
    repeat (2) @(negedge clk);
    exp_q.delete();
    rst_n = 1'b1;
    run_vec(post);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
